// File: rtl/platform_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : platform_scheduler_if
// Description : Control/status bundle for the platform scheduler.
//               master : frame_start, start, stop, speed, rd_idx (driven)
//                        rd_type, scroll_offset, base_idx, busy,
//                        wrap_pulse, frame_count (observed)
//               slave  : the reverse direction, used by the scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface platform_scheduler_if;
    logic        frame_start;
    logic        start;
    logic        stop;
    logic [3:0]  speed;
    logic [3:0]  rd_idx;
    logic [1:0]  rd_type;
    logic [6:0]  scroll_offset;
    logic [3:0]  base_idx;
    logic        busy;
    logic        wrap_pulse;
    logic [15:0] frame_count;

    modport master (
        output frame_start, start, stop, speed, rd_idx,
        input  rd_type, scroll_offset, base_idx, busy, wrap_pulse, frame_count
    );

    modport slave (
        input  frame_start, start, stop, speed, rd_idx,
        output rd_type, scroll_offset, base_idx, busy, wrap_pulse, frame_count
    );
endinterface
`default_nettype wire

// File: rtl/platform_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : platform_scheduler
// Description : Scrolling platform ring. Once per frame (frame_start in RUN)
//               the scroll offset advances by speed; when it passes PITCH
//               the bottom platform leaves, its slot is refilled with a new
//               type and the ring base advances.
// Ports       : clk, rst_n (async active-low)
//               bus (platform_scheduler_if.slave):
//                 in : frame_start, start, stop, speed[3:0], rd_idx[3:0]
//                 out: rd_type[1:0], scroll_offset[6:0], base_idx[3:0],
//                      busy, wrap_pulse, frame_count[15:0]
// Config      : PLATFORM_SCHEDULER_LFSR_EN - new types come from a 16-bit
//               LFSR; otherwise they follow (top type + 1) mod 3.
// Revision    : 1.0 - initial release
// ============================================================================
module platform_scheduler #(
    parameter int          N_PLATFORMS = 10,
    parameter int          PITCH       = 83,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    platform_scheduler_if.slave   bus
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_RUN    = 2'd1;
    localparam logic [1:0] c_UPDATE = 2'd2;
    localparam logic [1:0] c_WRAP   = 2'd3;

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic [6:0]  r_scroll_offset;
    logic [3:0]  r_base_idx;
    logic [15:0] r_frame_count;
    logic        r_stop_latch;
    logic [1:0]  r_table [N_PLATFORMS];

    logic [7:0]  w_sum;
    logic        w_sum_wraps;
    logic        w_stop_req;
    logic [3:0]  w_base_next;
    logic [1:0]  w_new_type;
    logic [4:0]  w_rd_sum;
    logic [3:0]  w_rd_slot;

    assign w_sum       = {1'b0, r_scroll_offset} + {4'd0, bus.speed};
    assign w_sum_wraps = (w_sum >= 8'(PITCH));
    assign w_stop_req  = bus.stop | r_stop_latch;
    assign w_base_next = (r_base_idx == 4'(N_PLATFORMS - 1)) ? 4'd0 : r_base_idx + 4'd1;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:   if (bus.start) w_next_state = c_RUN;
            c_RUN: begin
                if (bus.stop)             w_next_state = c_IDLE;
                else if (bus.frame_start) w_next_state = c_UPDATE;
            end
            c_UPDATE: begin
                if (w_sum_wraps)     w_next_state = c_WRAP;
                else if (w_stop_req) w_next_state = c_IDLE;
                else                 w_next_state = c_RUN;
            end
            c_WRAP:   w_next_state = w_stop_req ? c_IDLE : c_RUN;
            default:  w_next_state = c_IDLE;
        endcase
    end

    // ---------------- state-decoded outputs ----------------
    always_comb begin
        bus.busy       = (r_state != c_IDLE);
        bus.wrap_pulse = (r_state == c_WRAP);
    end

    // ---------------- datapath ----------------
    // The stop latch only needs to carry a stop seen in UPDATE across the
    // following WRAP cycle; every other path consumes stop directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scroll_offset <= 7'd0;
            r_base_idx      <= 4'd0;
            r_frame_count   <= 16'd0;
            r_stop_latch    <= 1'b0;
            for (int i = 0; i < N_PLATFORMS; i++) begin
                r_table[i] <= 2'(i % 3);
            end
        end else begin
            r_stop_latch <= (r_state == c_UPDATE) && w_sum_wraps && bus.stop;
            if (r_state == c_UPDATE) begin
                r_frame_count   <= r_frame_count + 16'd1;
                r_scroll_offset <= w_sum_wraps ? 7'(w_sum - 8'(PITCH)) : w_sum[6:0];
            end
            if (r_state == c_WRAP) begin
                r_table[r_base_idx] <= w_new_type;
                r_base_idx          <= w_base_next;
            end
        end
    end

`ifdef PLATFORM_SCHEDULER_LFSR_EN
    logic [15:0] r_lfsr;
    logic        w_lfsr_fb;

    // Fibonacci taps 16,14,13,11
    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= SEED;
        end else if (r_state == c_WRAP) begin
            r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
        end
    end

    // Fold the value 3 back into the 0..2 type range using the next bit pair.
    assign w_new_type = (r_lfsr[1:0] != 2'd3) ? r_lfsr[1:0] :
                        ((r_lfsr[3:2] == 2'd3) ? 2'd0 : r_lfsr[3:2]);
`else
    logic [3:0] w_top_slot;

    // The top of the display is the slot just below base in ring order.
    assign w_top_slot = (r_base_idx == 4'd0) ? 4'(N_PLATFORMS - 1) : r_base_idx - 4'd1;
    assign w_new_type = (r_table[w_top_slot] == 2'd2) ? 2'd0 : r_table[w_top_slot] + 2'd1;
`endif

    // ---------------- display-relative read ----------------
    assign w_rd_sum  = {1'b0, r_base_idx} + {1'b0, bus.rd_idx};
    assign w_rd_slot = (w_rd_sum >= 5'(N_PLATFORMS)) ? 4'(w_rd_sum - 5'(N_PLATFORMS))
                                                     : w_rd_sum[3:0];
    assign bus.rd_type = (bus.rd_idx >= 4'(N_PLATFORMS)) ? 2'd0 : r_table[w_rd_slot];

    assign bus.scroll_offset = r_scroll_offset;
    assign bus.base_idx      = r_base_idx;
    assign bus.frame_count   = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_platform_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_platform_scheduler
// Description : Directed self-checking bench for platform_scheduler
//               (default build: new type = top type + 1 mod 3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_platform_scheduler;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    int   w;
    int   wr;

    platform_scheduler_if bus ();

    platform_scheduler dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One frame: RUN -> UPDATE -> (WRAP ->) RUN; returns 1 if a wrap occurred.
    task automatic do_frame(input logic [3:0] spd, output int wraps);
        bus.speed       = spd;
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        tick();
        wraps = 0;
        if (bus.wrap_pulse) begin
            wraps = 1;
            tick();
        end
    endtask

    // After k total wraps, display slot d holds (k + d) mod 3.
    task automatic check_types(input int k);
        for (int d = 0; d < 10; d++) begin
            bus.rd_idx = 4'(d);
            #1;
            check("rd_type", 32'(bus.rd_type), 32'((k + d) % 3));
        end
        bus.rd_idx = 4'd0;
    endtask

    initial begin
        n_checks        = 0;
        n_errors        = 0;
        rst_n           = 1'b0;
        bus.frame_start = 1'b0;
        bus.start       = 1'b0;
        bus.stop        = 1'b0;
        bus.speed       = 4'd0;
        bus.rd_idx      = 4'd0;
        repeat (3) tick();

        // reset state
        check("rst_busy",   32'(bus.busy), 0);
        check("rst_offset", 32'(bus.scroll_offset), 0);
        check("rst_base",   32'(bus.base_idx), 0);
        check("rst_fc",     32'(bus.frame_count), 0);
        check("rst_wrap",   32'(bus.wrap_pulse), 0);
        check_types(0);

        rst_n = 1'b1;
        tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("start_busy",   32'(bus.busy), 1);
        check("start_offset", 32'(bus.scroll_offset), 0);
        check_types(0);

        // 16 frames at speed 5: reach 80 without wrapping
        wr = 0;
        for (int i = 0; i < 16; i++) begin
            do_frame(4'd5, w);
            wr += w;
        end
        check("s5_offset", 32'(bus.scroll_offset), 80);
        check("s5_wraps",  32'(wr), 0);
        check("s5_base",   32'(bus.base_idx), 0);
        check("s5_fc",     32'(bus.frame_count), 16);

        // 17th frame wraps
        do_frame(4'd5, w);
        check("w17_wrap",   32'(w), 1);
        check("w17_offset", 32'(bus.scroll_offset), 2);
        check("w17_base",   32'(bus.base_idx), 1);
        check("w17_fc",     32'(bus.frame_count), 17);
        check("w17_pulse",  32'(bus.wrap_pulse), 0);
        check_types(1);

        // walk to base 9, offset 80: 2+7 = 9, then 49*15 = 735 -> 744 = 8*83+80
        do_frame(4'd7, w);
        check("s7_offset", 32'(bus.scroll_offset), 9);
        wr = 0;
        for (int i = 0; i < 49; i++) begin
            do_frame(4'd15, w);
            wr += w;
        end
        check("s15_wraps",  32'(wr), 8);
        check("s15_base",   32'(bus.base_idx), 9);
        check("s15_offset", 32'(bus.scroll_offset), 80);
        check("s15_fc",     32'(bus.frame_count), 67);
        check("slot9_old",  32'(bus.rd_type), 0);

        // base 9 -> 0 wrap rewrites slot 9
        do_frame(4'd15, w);
        check("b9_wrap",   32'(w), 1);
        check("b9_offset", 32'(bus.scroll_offset), 12);
        check("b9_base",   32'(bus.base_idx), 0);
        check("b9_fc",     32'(bus.frame_count), 68);
        check_types(10);
        bus.rd_idx = 4'd10;
        #1;
        check("rd_oob10", 32'(bus.rd_type), 0);
        bus.rd_idx = 4'd15;
        #1;
        check("rd_oob15", 32'(bus.rd_type), 0);
        bus.rd_idx = 4'd0;

        // stop and frame_start together in RUN: stop wins
        bus.stop        = 1'b1;
        bus.frame_start = 1'b1;
        tick();
        bus.stop        = 1'b0;
        bus.frame_start = 1'b0;
        check("sf_busy",   32'(bus.busy), 0);
        check("sf_offset", 32'(bus.scroll_offset), 12);
        tick();
        check("sf_fc",     32'(bus.frame_count), 68);
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        tick();
        check("idle_fs_busy", 32'(bus.busy), 0);
        check("idle_fs_fc",   32'(bus.frame_count), 68);

        // stop during WRAP: wrap completes then IDLE
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) do_frame(4'd15, w);
        check("pre_wrap_offset", 32'(bus.scroll_offset), 72);
        bus.speed       = 4'd15;
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        tick();
        check("sw_pulse", 32'(bus.wrap_pulse), 1);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        check("sw_busy",   32'(bus.busy), 0);
        check("sw_base",   32'(bus.base_idx), 1);
        check("sw_offset", 32'(bus.scroll_offset), 4);
        check("sw_fc",     32'(bus.frame_count), 73);
        check("sw_pulse0", 32'(bus.wrap_pulse), 0);

        // stop during UPDATE of a wrapping frame is latched across WRAP
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 5; i++) do_frame(4'd15, w);
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        bus.stop        = 1'b1;
        tick();
        bus.stop = 1'b0;
        check("su_pulse", 32'(bus.wrap_pulse), 1);
        tick();
        check("su_busy",   32'(bus.busy), 0);
        check("su_base",   32'(bus.base_idx), 2);
        check("su_offset", 32'(bus.scroll_offset), 11);
        check("su_fc",     32'(bus.frame_count), 79);

        // frame_start held into UPDATE is not queued
        bus.start = 1'b1;
        tick();
        bus.start       = 1'b0;
        bus.speed       = 4'd3;
        bus.frame_start = 1'b1;
        tick();
        tick();
        bus.frame_start = 1'b0;
        tick();
        tick();
        check("nq_fc",     32'(bus.frame_count), 80);
        check("nq_offset", 32'(bus.scroll_offset), 14);

        // reset asserted mid-UPDATE
        bus.speed       = 4'd5;
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mr_offset", 32'(bus.scroll_offset), 0);
        check("mr_base",   32'(bus.base_idx), 0);
        check("mr_fc",     32'(bus.frame_count), 0);
        check("mr_busy",   32'(bus.busy), 0);
        check("mr_wrap",   32'(bus.wrap_pulse), 0);
        check_types(0);
        tick();
        rst_n = 1'b1;
        tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("rs_busy",   32'(bus.busy), 1);
        check("rs_offset", 32'(bus.scroll_offset), 0);
        do_frame(4'd5, w);
        check("rs_offset5", 32'(bus.scroll_offset), 5);
        check("rs_fc",      32'(bus.frame_count), 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
